// File: rtl/stall_ctrl_if.sv
// Hazard-unit signal bundle: D/E/M pipeline hazard inputs and stall/flush controls.
interface stall_ctrl_if;
  logic [31:0] IR_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic [4:0]  waddr_E;
  logic [1:0]  tnew_E;
  logic [4:0]  waddr_M;
  logic [1:0]  tnew_M;
  logic        md_start_E;
  logic        md_div_E;
  logic        md_use_D;
  logic        stall_F;
  logic        stall_D;
  logic        flush_E;
  logic        md_busy;
  logic [15:0] stall_cnt;

  modport master (
    output IR_D, tuse_rs_D, tuse_rt_D, waddr_E, tnew_E, waddr_M, tnew_M,
           md_start_E, md_div_E, md_use_D,
    input  stall_F, stall_D, flush_E, md_busy, stall_cnt
  );

  modport slave (
    input  IR_D, tuse_rs_D, tuse_rt_D, waddr_E, tnew_E, waddr_M, tnew_M,
           md_start_E, md_div_E, md_use_D,
    output stall_F, stall_D, flush_E, md_busy, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: register-operand hazards against E/M, mult/div
// occupancy countdown, and a saturating count of stalled cycles.
module stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  stall_ctrl_if.slave bus
);
  localparam logic [3:0] DIV_CYCLES = 4'd10;
  localparam logic [3:0] MUL_CYCLES = 4'd5;

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_haz_rs_e;
  logic        w_haz_rs_m;
  logic        w_haz_rt_e;
  logic        w_haz_rt_m;
  logic        w_reg_stall;
  logic        w_md_busy;
  logic        w_md_stall;
  logic        w_stall;
  logic        w_unused_ir;
  logic [3:0]  r_md_cnt;
  logic [15:0] r_stall_cnt;

  assign w_rs        = bus.IR_D[25:21];
  assign w_rt        = bus.IR_D[20:16];
  assign w_unused_ir = ^{bus.IR_D[31:26], bus.IR_D[15:0]};

  // tuse==3 marks an unused operand; it can never be strictly below any tnew
  // anyway, but the explicit guard keeps the intent visible.
  always_comb begin
    w_haz_rs_e = (bus.tuse_rs_D != 2'd3) && (bus.waddr_E != '0) &&
                 (w_rs == bus.waddr_E) && (bus.tuse_rs_D < bus.tnew_E);
    w_haz_rs_m = (bus.tuse_rs_D != 2'd3) && (bus.waddr_M != '0) &&
                 (w_rs == bus.waddr_M) && (bus.tuse_rs_D < bus.tnew_M);
    w_haz_rt_e = (bus.tuse_rt_D != 2'd3) && (bus.waddr_E != '0) &&
                 (w_rt == bus.waddr_E) && (bus.tuse_rt_D < bus.tnew_E);
    w_haz_rt_m = (bus.tuse_rt_D != 2'd3) && (bus.waddr_M != '0) &&
                 (w_rt == bus.waddr_M) && (bus.tuse_rt_D < bus.tnew_M);
    w_reg_stall = w_haz_rs_e | w_haz_rs_m | w_haz_rt_e | w_haz_rt_m;
  end

  assign w_md_busy  = (r_md_cnt != '0) | bus.md_start_E;
  assign w_md_stall = bus.md_use_D & w_md_busy;
  assign w_stall    = w_reg_stall | w_md_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (r_md_cnt == '0) begin
      if (bus.md_start_E) begin
        r_md_cnt <= bus.md_div_E ? DIV_CYCLES : MUL_CYCLES;
      end
    end else begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_F   = w_stall;
  assign bus.stall_D   = w_stall;
  assign bus.flush_E   = w_stall;
  assign bus.md_busy   = w_md_busy;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed literal scenarios plus randomized traffic
// compared every cycle against a cycle-indexed behavioural model.
module tb_stall_ctrl;
  logic clk;
  logic reset;
  stall_ctrl_if bus();

  stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: cycle index plus the first cycle at which the mult/div unit is idle.
  int cyc      = 0;
  int busy_end = 0;
  int m_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    return (cyc < busy_end) || (bus.md_start_E == 1'b1);
  endfunction

  function automatic bit model_stall();
    logic [4:0] src [2];
    logic [1:0] tu  [2];
    logic [4:0] dst [2];
    logic [1:0] tn  [2];
    bit s;
    s = 1'b0;
    src[0] = bus.IR_D[25:21]; tu[0] = bus.tuse_rs_D;
    src[1] = bus.IR_D[20:16]; tu[1] = bus.tuse_rt_D;
    dst[0] = bus.waddr_E;     tn[0] = bus.tnew_E;
    dst[1] = bus.waddr_M;     tn[1] = bus.tnew_M;
    for (int i = 0; i < 2; i++)
      if (tu[i] != 2'd3)
        for (int j = 0; j < 2; j++)
          if (dst[j] != 5'd0 && dst[j] == src[i] && tu[i] < tn[j]) s = 1'b1;
    return s || (bus.md_use_D && model_busy());
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt    = 0;
      busy_end = cyc;
    end else begin
      if (model_stall() && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (bus.md_start_E && cyc >= busy_end) busy_end = cyc + 1 + (bus.md_div_E ? 10 : 5);
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall_F",   32'(bus.stall_F),   32'(model_stall()));
      chk("m_stall_D",   32'(bus.stall_D),   32'(model_stall()));
      chk("m_flush_E",   32'(bus.flush_E),   32'(model_stall()));
      chk("m_md_busy",   32'(bus.md_busy),   32'(model_busy()));
      chk("m_stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IR_D       = '0;
    bus.tuse_rs_D  = 2'd3;
    bus.tuse_rt_D  = 2'd3;
    bus.waddr_E    = '0;
    bus.tnew_E     = '0;
    bus.waddr_M    = '0;
    bus.tnew_M     = '0;
    bus.md_start_E = 1'b0;
    bus.md_div_E   = 1'b0;
    bus.md_use_D   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_md_busy",   32'(bus.md_busy),   32'd0);
    chk("rst_stall_F",   32'(bus.stall_F),   32'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    chk_en = 1'b1;
    do_reset();

    // Load-use on rs against E.
    bus.IR_D = 32'h00A0_0000;  // rs=5
    bus.waddr_E = 5'd5; bus.tnew_E = 2'd2; bus.tuse_rs_D = 2'd1;
    #2;
    chk("lu_stall_F", 32'(bus.stall_F), 32'd1);
    chk("lu_stall_D", 32'(bus.stall_D), 32'd1);
    chk("lu_flush_E", 32'(bus.flush_E), 32'd1);
    tick();
    idle_inputs();
    #2;
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("lu_clear", 32'(bus.stall_F), 32'd0);

    // $0 destination and don't-care rt operand.
    bus.IR_D = 32'h0007_0000;  // rs=0, rt=7
    bus.tnew_E = 2'd2; bus.tuse_rs_D = 2'd0;
    bus.waddr_M = 5'd7; bus.tnew_M = 2'd3; bus.tuse_rt_D = 2'd3;
    #2;
    chk("zero_dc_stall", 32'(bus.stall_F), 32'd0);
    bus.tuse_rt_D = 2'd0; bus.tnew_M = 2'd1;
    #2;
    chk("rt_m_stall", 32'(bus.stall_F), 32'd1);
    tick();
    chk("rt_m_cnt", 32'(bus.stall_cnt), 32'd2);

    // Divide: busy for the start cycle plus ten countdown cycles.
    do_reset();
    bus.md_use_D = 1'b1; bus.md_start_E = 1'b1; bus.md_div_E = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #2;
      chk("div_busy", 32'(bus.md_busy), 32'd1);
      chk("div_stall", 32'(bus.stall_F), 32'd1);
      tick();
      bus.md_start_E = 1'b0;
    end
    #2;
    chk("div_done_busy", 32'(bus.md_busy), 32'd0);
    chk("div_done_stall", 32'(bus.stall_F), 32'd0);
    chk("div_cnt", 32'(bus.stall_cnt), 32'd11);

    // Multiply with a second start while counting: no reload.
    do_reset();
    bus.md_start_E = 1'b1; bus.md_div_E = 1'b0;
    tick();
    bus.md_start_E = 1'b0;
    tick();
    tick();
    bus.md_start_E = 1'b1;
    #2;
    chk("mul_busy3", 32'(bus.md_busy), 32'd1);
    tick();
    bus.md_start_E = 1'b0;
    #2;
    chk("mul_busy2", 32'(bus.md_busy), 32'd1);
    tick();
    #2;
    chk("mul_busy1", 32'(bus.md_busy), 32'd1);
    tick();
    #2;
    chk("mul_noreload", 32'(bus.md_busy), 32'd0);

    // Reset in the middle of a divide takes effect without a clock edge.
    do_reset();
    bus.md_use_D = 1'b1; bus.md_start_E = 1'b1; bus.md_div_E = 1'b1;
    tick();
    bus.md_start_E = 1'b0;
    repeat (4) tick();
    #2;
    chk("mid_cnt", 32'(bus.stall_cnt), 32'd5);
    reset = 1'b1;
    #1;
    chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("mid_rst_busy", 32'(bus.md_busy), 32'd0);
    bus.md_start_E = 1'b1;
    #1;
    chk("mid_rst_start", 32'(bus.md_busy), 32'd1);
    bus.md_start_E = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    #2;
    chk("mid_after", 32'(bus.md_busy), 32'd0);

    // Randomized traffic with small register indices to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      bus.IR_D       = {6'($urandom), 2'b0, 3'($urandom), 2'b0, 3'($urandom), 16'($urandom)};
      bus.tuse_rs_D  = 2'($urandom);
      bus.tuse_rt_D  = 2'($urandom);
      bus.waddr_E    = 5'($urandom_range(0, 7));
      bus.tnew_E     = 2'($urandom);
      bus.waddr_M    = 5'($urandom_range(0, 7));
      bus.tnew_M     = 2'($urandom);
      bus.md_start_E = ($urandom_range(0, 7) == 0);
      bus.md_div_E   = 1'($urandom);
      bus.md_use_D   = ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    // Saturation of the stall counter.
    do_reset();
    bus.IR_D = 32'h00A0_0000;
    bus.waddr_E = 5'd5; bus.tnew_E = 2'd2; bus.tuse_rs_D = 2'd1;
    repeat (65534) tick();
    #2;
    chk("sat_fffe", 32'(bus.stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("sat_ffff", 32'(bus.stall_cnt), 32'hFFFF);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
